// File: rtl/kuz_round_key_store_if.sv
// Round-key store bus: key fill side (from key expansion) and read side (to round engine).
// master = upstream/engine driving requests; slave = the key store.
interface kuz_round_key_store_if #(
    parameter int KEY_BITS = 128
);
    logic                load_start;
    logic                key_valid_s;
    logic [KEY_BITS-1:0] key_din;
    logic                keys_ready;
    logic [3:0]          key_count;
    logic                key_ovf;
    logic                seq_start;
    logic                normal_inverse_n;
    logic                rk_req;
    logic                rk_valid_s;
    logic [KEY_BITS-1:0] rk_dout;
    logic                seq_last;

    modport master (
        output load_start, key_valid_s, key_din, seq_start, normal_inverse_n, rk_req,
        input  keys_ready, key_count, key_ovf, rk_valid_s, rk_dout, seq_last
    );

    modport slave (
        input  load_start, key_valid_s, key_din, seq_start, normal_inverse_n, rk_req,
        output keys_ready, key_count, key_ovf, rk_valid_s, rk_dout, seq_last
    );
endinterface

// File: rtl/kuz_round_key_store.sv
// Round-key buffer: fills NKEYS keys, then serves them forward or reverse at 1-cycle latency.
// Optional KUZ_KEY_ZEROIZE_EN clears key entries and rk_dout on reset/load_start.
module kuz_round_key_store #(
    parameter int NKEYS    = 10,
    parameter int KEY_BITS = 128
) (
    input  logic                   clk,
    input  logic                   reset,
    kuz_round_key_store_if.slave   bus
);
    localparam logic [3:0] LAST_IDX = 4'(NKEYS - 1);
    localparam logic [3:0] FULL_CNT = 4'(NKEYS);

    typedef enum logic [1:0] {W_EMPTY, W_FILL, W_FULL} wstate_t;
    typedef enum logic       {R_IDLE, R_ACTIVE}         rstate_t;

    wstate_t             wstate, wstate_nxt;
    logic [3:0]          count, count_nxt;
    logic                ovf, ovf_nxt;
    logic                wr_en;
    logic                keys_ready;
    logic [KEY_BITS-1:0] entry [NKEYS];

    rstate_t             rstate, rstate_nxt;
    logic [3:0]          ptr, ptr_nxt;
    logic                dir, dir_nxt;
    logic                vld, vld_nxt;
    logic                last, last_nxt;
    logic [KEY_BITS-1:0] dout, dout_nxt;
    logic [3:0]          end_idx;

    assign keys_ready = (wstate == W_FULL);

    // Write side: load_start wins over a coincident key_valid_s
    always_comb begin
        wstate_nxt = wstate;
        count_nxt  = count;
        ovf_nxt    = ovf;
        wr_en      = 1'b0;
        if (bus.load_start) begin
            wstate_nxt = W_EMPTY;
            count_nxt  = 4'd0;
            ovf_nxt    = 1'b0;
        end else if (bus.key_valid_s) begin
            if (wstate == W_FULL) begin
                ovf_nxt = 1'b1;
            end else begin
                wr_en      = 1'b1;
                count_nxt  = count + 4'd1;
                wstate_nxt = (count + 4'd1 == FULL_CNT) ? W_FULL : W_FILL;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wstate <= W_EMPTY;
            count  <= 4'd0;
            ovf    <= 1'b0;
        end else begin
            wstate <= wstate_nxt;
            count  <= count_nxt;
            ovf    <= ovf_nxt;
        end
    end

`ifdef KUZ_KEY_ZEROIZE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry <= '{default: '0};
        end else if (bus.load_start) begin
            entry <= '{default: '0};
        end else if (wr_en) begin
            entry[count] <= bus.key_din;
        end
    end
`else
    // Key material is deliberately not reset; only count and flags clear
    always_ff @(posedge clk) begin
        if (wr_en) begin
            entry[count] <= bus.key_din;
        end
    end
`endif

    // Read side: load_start aborts, accepted seq_start restarts; both swallow rk_req
    always_comb begin
        rstate_nxt = rstate;
        ptr_nxt    = ptr;
        dir_nxt    = dir;
        vld_nxt    = 1'b0;
        last_nxt   = 1'b0;
        dout_nxt   = dout;
        end_idx    = dir ? LAST_IDX : 4'd0;
        if (bus.load_start) begin
            rstate_nxt = R_IDLE;
`ifdef KUZ_KEY_ZEROIZE_EN
            dout_nxt   = '0;
`endif
        end else if (bus.seq_start && keys_ready) begin
            rstate_nxt = R_ACTIVE;
            dir_nxt    = bus.normal_inverse_n;
            ptr_nxt    = bus.normal_inverse_n ? 4'd0 : LAST_IDX;
        end else if (rstate == R_ACTIVE && bus.rk_req) begin
            vld_nxt  = 1'b1;
            dout_nxt = entry[ptr];
            last_nxt = (ptr == end_idx);
            if (ptr == end_idx) begin
                rstate_nxt = R_IDLE;
            end else begin
                ptr_nxt = dir ? ptr + 4'd1 : ptr - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rstate <= R_IDLE;
            ptr    <= 4'd0;
            dir    <= 1'b0;
            vld    <= 1'b0;
            last   <= 1'b0;
            dout   <= '0;
        end else begin
            rstate <= rstate_nxt;
            ptr    <= ptr_nxt;
            dir    <= dir_nxt;
            vld    <= vld_nxt;
            last   <= last_nxt;
            dout   <= dout_nxt;
        end
    end

    assign bus.keys_ready = keys_ready;
    assign bus.key_count  = count;
    assign bus.key_ovf    = ovf;
    assign bus.rk_valid_s = vld;
    assign bus.rk_dout    = dout;
    assign bus.seq_last   = last;
endmodule
